// File: rtl/enc4to2_debounce_if.sv
// Bus bundle for the debounced 4-to-2 priority encoder.
// Handshake: valid is a one-cycle pulse with no ready/backpressure. The consumer
// must take code/multi in the cycle valid is high. code and multi stay stable
// between pulses. dbg_state mirrors the encoder FSM state so checkers can bind to it.
interface enc4to2_debounce_if;
  logic       en;
  logic [3:0] d;
  logic [1:0] code;
  logic       valid;
  logic       multi;
  logic       busy;
  logic [1:0] dbg_state;

  modport master (
    output en, d,
    input  code, valid, multi, busy, dbg_state
  );

  modport slave (
    input  en, d,
    output code, valid, multi, busy, dbg_state
  );
endinterface

// File: rtl/enc4to2_debounce.sv
// Sequential 4-to-2 priority encoder with per-line synchronizer and stability
// filter. A nonzero pattern must hold STABLE_CNT synchronized cycles to be
// accepted (one valid pulse). It must then read zero for STABLE_CNT cycles
// before another press can be captured.
module enc4to2_debounce #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input logic            clk,
  input logic            rst,
  enc4to2_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // The entry cycle of SETTLE/RELEASE counts as 1, so the last count is STABLE_CNT-1.
  // With STABLE_CNT=1 that would be 0, which a counter starting at 1 never reaches.
  // ONE_SHOT makes the exit happen on the edge after entry in that case.
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam bit               ONE_SHOT = (STABLE_CNT == 1);

  state_t           state, state_n;
  logic [3:0]       sync1, d_s;
  logic [3:0]       snap, snap_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       code_r, code_n;
  logic             multi_r, multi_n;
  logic             valid_r, valid_n;
  logic             cnt_done;

  // Highest set bit wins; an all-zero word never reaches this (snap is nonzero when used).
  function automatic logic [1:0] enc(input logic [3:0] v);
    logic [1:0] r;
    if (v[3])      r = 2'd3;
    else if (v[2]) r = 2'd2;
    else if (v[1]) r = 2'd1;
    else           r = 2'd0;
    return r;
  endfunction

  // More than one bit set: clearing the lowest set bit leaves something behind.
  function automatic logic multi_of(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

  // Two-flop synchronizer on the raw request lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 4'b0000;
      d_s   <= 4'b0000;
    end else begin
      sync1 <= bus.d;
      d_s   <= sync1;
    end
  end

  // State, filter counter, snapshot and latched outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      snap    <= 4'b0000;
      cnt     <= '0;
      code_r  <= 2'b00;
      multi_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state   <= state_n;
      snap    <= snap_n;
      cnt     <= cnt_n;
      code_r  <= code_n;
      multi_r <= multi_n;
      valid_r <= valid_n;
    end
  end

  assign cnt_done = ONE_SHOT || (cnt == CNT_LAST);

  // Next-state and next-output logic. en only matters in IDLE and SETTLE.
  always_comb begin
    state_n = state;
    snap_n  = snap;
    cnt_n   = cnt;
    code_n  = code_r;
    multi_n = multi_r;
    valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en && (d_s != 4'b0000)) begin
          snap_n  = d_s;
          cnt_n   = CNT_ONE;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (!bus.en || (d_s == 4'b0000)) begin
          state_n = IDLE;
        end else if (d_s != snap) begin
          // A new pattern, such as a later rising higher bit, restarts the filter.
          snap_n = d_s;
          cnt_n  = CNT_ONE;
        end else if (cnt_done) begin
          state_n = HELD;
          code_n  = enc(snap);
          multi_n = multi_of(snap);
          valid_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (d_s == 4'b0000) begin
          cnt_n   = CNT_ONE;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (d_s != 4'b0000) begin
          state_n = HELD;
        end else if (cnt_done) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.code      = code_r;
  assign bus.multi     = multi_r;
  assign bus.valid     = valid_r;
  assign bus.busy      = (state != IDLE);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_enc4to2_debounce.sv
// Bench for enc4to2_debounce. Reference model works on synchronized samples.
// A press is accepted once a run of identical nonzero samples with en=1 reaches
// the threshold. A press ends once a run of zero samples reaches the threshold.
module tb_enc4to2_debounce;

  localparam int STABLE_CNT = 4;
  localparam int CNT_W      = 8;
  localparam int THR        = (STABLE_CNT < 2) ? 2 : STABLE_CNT;

  logic clk;
  logic rst;
  enc4to2_debounce_if bus ();

  enc4to2_debounce #(.STABLE_CNT(STABLE_CNT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters and scoreboard
  int n_cmp  = 0;
  int n_fail = 0;
  logic [2:0] exp_q[$];

  // Reference model state
  logic [3:0] m_s1, m_s2, m_last;
  int         m_run, m_zero;
  bit         m_pressed;
  logic [1:0] m_code;
  logic       m_multi, m_valid;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 4'b0; m_s2 = 4'b0; m_last = 4'b0;
    m_run = 0; m_zero = 0; m_pressed = 1'b0;
    m_code = 2'b00; m_multi = 1'b0; m_valid = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [1:0] top_bit(input logic [3:0] v);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // One rising edge worth of model behaviour, using the values driven on d/en.
  task automatic model_step();
    logic [3:0] smp;
    if (rst) return;
    smp = m_s2;
    m_s2 = m_s1;
    m_s1 = bus.d;
    m_valid = 1'b0;
    if (!m_pressed) begin
      if (bus.en && smp != 4'b0) begin
        m_run = (m_run > 0 && smp == m_last) ? m_run + 1 : 1;
        m_last = smp;
      end else begin
        m_run = 0;
      end
      if (m_run == THR) begin
        m_pressed = 1'b1;
        m_run = 0;
        m_zero = 0;
        m_valid = 1'b1;
        m_code = top_bit(smp);
        m_multi = ($countones(smp) > 1);
        exp_q.push_back({m_multi, m_code});
      end
    end else begin
      m_zero = (smp == 4'b0) ? m_zero + 1 : 0;
      if (m_zero == THR) begin
        m_pressed = 1'b0;
        m_zero = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [2:0] e;
    chk("valid", 8'(bus.valid), 8'(m_valid));
    chk("code",  8'(bus.code),  8'(m_code));
    chk("multi", 8'(bus.multi), 8'(m_multi));
    chk("busy",  8'(bus.busy),  8'(m_pressed || m_run > 0));
    if (bus.valid === 1'b1) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pulse", 8'({bus.multi, bus.code}), 8'(e));
      end else begin
        chk("sb_extra", 8'(1), 8'(0));
      end
    end
  endtask

  // Driver: apply d/en, take one edge, then check #1 after it.
  task automatic cyc(input logic [3:0] dv, input logic ev);
    bus.d = dv;
    bus.en = ev;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic run(input logic [3:0] dv, input logic ev, input int n,
                     output int nv, output int first, output int lo, output int hi_all);
    nv = 0; first = 0; lo = 0; hi_all = 1;
    for (int i = 1; i <= n; i++) begin
      cyc(dv, ev);
      if (bus.valid === 1'b1) begin
        nv++;
        if (first == 0) first = i;
      end
      if (bus.busy !== 1'b1) begin
        hi_all = 0;
        if (lo == 0) lo = i;
      end
    end
  endtask

  initial begin
    int nv, first, lo, hi, tot;
    logic [3:0] rd;
    logic       re;
    int         hold;

    model_reset();
    rst = 1'b1;
    bus.d = 4'b0;
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_code",  8'(bus.code),  8'(0));
    chk("rst_valid", 8'(bus.valid), 8'(0));
    chk("rst_busy",  8'(bus.busy),  8'(0));
    chk("rst_multi", 8'(bus.multi), 8'(0));
    rst = 1'b0;

    // 1: clean press of 0100 and release
    run(4'b0100, 1'b1, 20, nv, first, lo, hi);
    chk("t1_nvalid", 8'(nv), 8'(1));
    chk("t1_lat", 8'(first), 8'(STABLE_CNT + 2));
    chk("t1_code", 8'(bus.code), 8'(2));
    chk("t1_busy", 8'(bus.busy), 8'(1));
    run(4'b0000, 1'b1, 6, nv, first, lo, hi);
    chk("t1_rel_busy", 8'(bus.busy), 8'(0));
    chk("t1_rel_code", 8'(bus.code), 8'(2));

    // 2: priority and multi
    run(4'b1011, 1'b1, 10, nv, first, lo, hi);
    chk("t2a_nvalid", 8'(nv), 8'(1));
    chk("t2a_code", 8'({bus.multi, bus.code}), 8'(3'b111));
    run(4'b0000, 1'b1, 8, nv, first, lo, hi);
    run(4'b0001, 1'b1, 10, nv, first, lo, hi);
    chk("t2b_nvalid", 8'(nv), 8'(1));
    chk("t2b_code", 8'({bus.multi, bus.code}), 8'(3'b000));
    run(4'b0000, 1'b1, 8, nv, first, lo, hi);

    // 3: bounce rejection
    tot = 0;
    for (int k = 0; k < 4; k++) begin
      run(4'b0001, 1'b1, 2, nv, first, lo, hi); tot += nv;
      run(4'b0000, 1'b1, 2, nv, first, lo, hi); tot += nv;
    end
    chk("t3_bounce_nvalid", 8'(tot), 8'(0));
    run(4'b0001, 1'b1, 12, nv, first, lo, hi);
    chk("t3_nvalid", 8'(nv), 8'(1));
    chk("t3_lat", 8'(first), 8'(STABLE_CNT + 2));
    chk("t3_code", 8'(bus.code), 8'(0));
    run(4'b0000, 1'b1, 8, nv, first, lo, hi);

    // 4: release bounce
    run(4'b0010, 1'b1, 10, nv, first, lo, hi);
    chk("t4_accept", 8'(nv), 8'(1));
    tot = 0;
    run(4'b0000, 1'b1, 2, nv, first, lo, hi); tot += nv;
    run(4'b0010, 1'b1, 1, nv, first, lo, hi); tot += nv;
    run(4'b0000, 1'b1, 10, nv, first, lo, hi); tot += nv;
    chk("t4_no_second", 8'(tot), 8'(0));
    chk("t4_busy_drop", 8'(lo), 8'(STABLE_CNT + 2));
    chk("t4_code", 8'(bus.code), 8'(1));

    // 5: enable gating
    run(4'b1000, 1'b0, 10, nv, first, lo, hi);
    chk("t5_gated_nvalid", 8'(nv), 8'(0));
    chk("t5_gated_busy", 8'(lo), 8'(1));
    run(4'b1000, 1'b1, 8, nv, first, lo, hi);
    chk("t5_lat", 8'(first), 8'(STABLE_CNT));
    chk("t5_code", 8'(bus.code), 8'(3));
    run(4'b1000, 1'b0, 5, nv, first, lo, hi);
    chk("t5_held_busy", 8'(hi), 8'(1));
    run(4'b0000, 1'b0, 8, nv, first, lo, hi);
    chk("t5_done_busy", 8'(bus.busy), 8'(0));

    // 6: async reset while HELD
    run(4'b0100, 1'b1, 10, nv, first, lo, hi);
    chk("t6_held_code", 8'(bus.code), 8'(2));
    chk("t6_held_busy", 8'(bus.busy), 8'(1));
    #3 rst = 1'b1;
    #1;
    chk("t6_async_code",  8'(bus.code),  8'(0));
    chk("t6_async_busy",  8'(bus.busy),  8'(0));
    chk("t6_async_valid", 8'(bus.valid), 8'(0));
    chk("t6_async_multi", 8'(bus.multi), 8'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(4'b0100, 1'b1, 12, nv, first, lo, hi);
    chk("t6_repress_nvalid", 8'(nv), 8'(1));
    chk("t6_repress_lat", 8'(first), 8'(STABLE_CNT + 2));
    chk("t6_repress_code", 8'(bus.code), 8'(2));
    run(4'b0000, 1'b1, 8, nv, first, lo, hi);

    // Randomized patterns, hold times and enable
    for (int k = 0; k < 120; k++) begin
      rd = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      re = ($urandom_range(0, 7) != 0);
      hold = $urandom_range(1, 9);
      run(rd, re, hold, nv, first, lo, hi);
    end
    run(4'b0000, 1'b1, 10, nv, first, lo, hi);
    chk("sb_drained", 8'(exp_q.size()), 8'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/enc4to2_debounce.md
Name: enc4to2_debounce

Overview:
- Sequential 4-to-2 priority encoder for a bank of four request/key lines. It is the inverse of the team's 2-to-4 one-hot decoder: a one-hot word in gives a 2-bit index out.
- Each input line passes through a synchronizer and a stability (debounce) filter.
- Produces exactly one valid pulse per press, with a latched index code and a multi-press flag.
- Sits between raw board switches/buttons and downstream logic that consumes a decoded index.

Parameters:
- STABLE_CNT, 4: consecutive synchronized cycles an input pattern must hold before it is accepted. The same count applies to release. Legal range 1..255.
- CNT_W, 8: width of the internal stability counter. Must satisfy 2^CNT_W > STABLE_CNT.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  encoder enable. Low holds the block in or returns it to IDLE, except from HELD/RELEASE.
- d  input  4  raw request lines, asynchronous to clk. d[3] has highest priority.
- code  output  2  latched index of the highest-priority asserted bit of the accepted pattern.
- valid  output  1  one-cycle pulse when a new pattern is accepted.
- multi  output  1  latched with code; 1 if the accepted pattern had more than one bit set.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-high: rst asserted forces all state immediately, independent of clk.
  - Reset values: code=2'b00, valid=0, multi=0, busy=0, state=IDLE, counter=0, synchronizer and snapshot registers=4'b0000.
- Synchronizer:
  - d passes through a 2-flop synchronizer to give d_s.
  - All decisions use d_s only.
- Encoding, applied to the snapshot:
  - 1xxx -> 11
  - 01xx -> 10
  - 001x -> 01
  - 0001 -> 00
  - multi = (popcount(snap) > 1).
- State machine, evaluated each rising edge:
  - IDLE:
    - If en=1 and d_s != 0: snap <= d_s, cnt <= 1, go to SETTLE.
    - Else stay in IDLE.
  - SETTLE:
    - If en=0 or d_s == 0: go to IDLE (no output change).
    - Else if d_s != snap: snap <= d_s, cnt <= 1 (restart filter), stay in SETTLE.
    - Else if cnt == STABLE_CNT-1: go to HELD; code <= enc(snap); multi <= multi(snap); valid <= 1 for exactly one cycle.
    - Else cnt <= cnt+1.
  - HELD:
    - Wait for release; en is ignored.
    - If d_s == 0: cnt <= 1, go to RELEASE.
    - A changed nonzero pattern produces no new valid.
  - RELEASE:
    - If d_s != 0: go back to HELD (bounce on release; no valid).
    - Else if cnt == STABLE_CNT-1: go to IDLE.
    - Else cnt <= cnt+1.
- STABLE_CNT=1 rules:
  - Acceptance happens on the edge after entering SETTLE.
  - Release exit happens on the edge after entering RELEASE.
  - The count comparisons treat the entry cycle as count 1.
- Latency:
  - A clean pattern held on d is first captured by the synchronizer at edge E.
  - valid is high in the cycle following edge E+1+STABLE_CNT.
  - For STABLE_CNT=4: valid is high after edge E+5.
- Output holding:
  - code and multi hold their last accepted value until the next valid. They are not cleared on release.
  - valid never asserts on two consecutive cycles.
- Boundary conditions:
  - Simultaneous bits: highest index wins and multi=1.
  - A later rise of a higher bit before acceptance restarts the filter with the new snapshot.
  - rst asserted mid-SETTLE or mid-HELD: immediate return to the reset values. A still-pressed input after reset release is treated as a new press (it passes IDLE->SETTLE again) and produces a fresh valid.
  - en deasserted in HELD or RELEASE has no effect until IDLE is reached. Once in IDLE, en=0 blocks new captures.
  - Counter never wraps: it is bounded by STABLE_CNT-1 < 2^CNT_W.

Test Plan:
1. Reset then clean press: STABLE_CNT=4, rst pulse, d=4'b0100 held 20 cycles -> after reset code=00, valid=0, busy=0. valid is a single pulse 6 edges after d is first sampled, with code=10, multi=0, busy=1. Release d=0 for 6 cycles -> busy=0, code stays 10.
2. Priority and multi: d=4'b1011 held -> one valid, code=11, multi=1. Then d=4'b0001 after full release -> one valid, code=00, multi=0.
3. Bounce rejection: d toggles between 0001 and 0000 every 2 cycles for 16 cycles, then holds 0001 -> no valid during toggling. Exactly one valid (code=00) STABLE_CNT+2 edges after the final stable hold begins.
4. Release bounce: after acceptance of 0010, d goes 0000 for 2 cycles, 0010 for 1 cycle, then 0000 held -> no second valid. busy drops STABLE_CNT edges (plus synchronizer delay) after the final 0000. code stays 01.
5. Enable gating: en=0 with d=1000 held 10 cycles -> no valid, busy stays 0. Raise en -> valid after STABLE_CNT edges, code=11. Dropping en while in HELD leaves busy=1 until release completes.
6. Async reset mid-HELD: assert rst between clock edges while HELD with d=0100 still pressed -> outputs go to reset values immediately without a clock edge. After rst deasserts, a new valid with code=10 follows the normal latency.
